// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if: byte-wide memory port between the blitter and its RAM.
// Read side: mem_read/mem_read_idx out, mem_read_byte/mem_read_ack back.
// Write side: mem_write/mem_write_idx/mem_write_byte out, no acknowledge.
// master = blitter, slave = memory.
interface sprite_blitter_if;
    logic        mem_read;
    logic [11:0] mem_read_idx;
    logic [7:0]  mem_read_byte;
    logic        mem_read_ack;
    logic        mem_write;
    logic [11:0] mem_write_idx;
    logic [7:0]  mem_write_byte;

    modport master (
        output mem_read,
        output mem_read_idx,
        input  mem_read_byte,
        input  mem_read_ack,
        output mem_write,
        output mem_write_idx,
        output mem_write_byte
    );

    modport slave (
        input  mem_read,
        input  mem_read_idx,
        output mem_read_byte,
        output mem_read_ack,
        input  mem_write,
        input  mem_write_idx,
        input  mem_write_byte
    );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter: XOR-draws 8xN / 16x16 sprites into a 1bpp framebuffer, or clears it.
// Ports: clk, rst_n (async, active-low); draw/clear start strobes; wide, wrap,
// addr, lines, x, y sprite parameters; busy, done, collision, collision_rows
// status; bus = memory port (master side of sprite_blitter_if).
module sprite_blitter #(
    parameter int          SCREEN_W = 64,
    parameter int          SCREEN_H = 32,
    parameter logic [11:0] FB_BASE  = 12'h100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             draw,
    input  logic             clear,
    input  logic             wide,
    input  logic             wrap,
    input  logic [11:0]      addr,
    input  logic [3:0]       lines,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    output logic             busy,
    output logic             done,
    output logic             collision,
    output logic [4:0]       collision_rows,
    sprite_blitter_if.master bus
);
    localparam int RB   = SCREEN_W / 8;
    localparam int NCLR = RB * SCREEN_H;

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_CLEAR       = 3'd1;
    localparam logic [2:0] S_LOAD_SPR_HI = 3'd2;
    localparam logic [2:0] S_LOAD_SPR_LO = 3'd3;
    localparam logic [2:0] S_LOAD_SCR    = 3'd4;
    localparam logic [2:0] S_STORE_SCR   = 3'd5;
    localparam logic [2:0] S_NEXT_ROW    = 3'd6;

    logic [2:0]  state;
    logic [11:0] cnt;
    logic [11:0] base;
    logic [6:0]  xq;
    logic [6:0]  row;
    logic [4:0]  r;
    logic [4:0]  rows;
    logic        wide_q;
    logic        wrap_q;
    logic [7:0]  spr_hi;
    logic [7:0]  spr_lo;
    logic [7:0]  old_b;
    logic [2:0]  pend;
    logic        row_flip;

    logic [6:0]  x_mod;
    logic [6:0]  y_mod;
    logic [4:0]  rows_in;

    assign x_mod   = 7'(int'(x) % SCREEN_W);
    assign y_mod   = 7'(int'(y) % SCREEN_H);
    assign rows_in = (wide && lines == 4'd0) ? 5'd16 : {1'b0, lines};

    logic [2:0]  sh;
    logic [3:0]  c0;
    logic [23:0] pat;
    logic [1:0]  nb_last;
    logic [2:0]  vmask;
    logic [1:0]  k_sel;
    logic [4:0]  col_raw;
    logic [4:0]  col;
    logic [7:0]  pk;
    logic [11:0] fb_idx;
    logic [11:0] spr_idx;
    logic        flip;
    logic [2:0]  pend_nx;
    logic [7:0]  row_nx;
    logic        is_load;
    logic        rd;
    logic        clr_wr;
    logic        st_wr;

    assign sh      = xq[2:0];
    assign c0      = xq[6:3];
    // spr_lo is zeroed for narrow sprites, so one 24-bit shift serves both widths
    assign pat     = {spr_hi, spr_lo, 8'h00} >> sh;
    assign nb_last = wide_q ? 2'd2 : 2'd1;
    assign row_nx  = {1'b0, row} + 8'd1;

    // Bytes of the shifted row that actually touch the screen. Byte 0 is
    // always present, so a row never ends up with nothing to do.
    always_comb begin
        vmask = '0;
        for (int k = 0; k < 3; k++) begin
            vmask[k] = (2'(k) <= nb_last)
                    && !(sh == 3'd0 && 2'(k) == nb_last)
                    && (wrap_q || ({1'b0, c0} + 5'(k)) < 5'(RB));
        end
    end

    always_comb begin
        if (pend[0])      k_sel = 2'd0;
        else if (pend[1]) k_sel = 2'd1;
        else              k_sel = 2'd2;
    end

    always_comb begin
        col_raw = {1'b0, c0} + {3'b000, k_sel};
        col     = (col_raw >= 5'(RB)) ? col_raw - 5'(RB) : col_raw;
        case (k_sel)
            2'd0:    pk = pat[23:16];
            2'd1:    pk = pat[15:8];
            default: pk = pat[7:0];
        endcase
    end

    assign fb_idx  = FB_BASE + 12'(row) * 12'(RB) + 12'(col);
    assign spr_idx = base
                   + 12'(wide_q ? {r, 1'b0} : {1'b0, r})
                   + 12'(state == S_LOAD_SPR_LO);
    assign flip    = |(old_b & pk);
    assign pend_nx = pend & ~(3'b001 << k_sel);

    assign is_load = (state == S_LOAD_SPR_HI)
                  || (state == S_LOAD_SPR_LO)
                  || (state == S_LOAD_SCR);
    assign rd      = is_load && !bus.mem_read_ack;
    assign clr_wr  = (state == S_CLEAR) && (cnt != 12'(NCLR));
    assign st_wr   = (state == S_STORE_SCR);
    assign busy    = (state != S_IDLE);

    always_comb begin
        bus.mem_read       = rd;
        bus.mem_read_idx   = 12'h000;
        bus.mem_write      = clr_wr || st_wr;
        bus.mem_write_idx  = 12'h000;
        bus.mem_write_byte = 8'h00;
        if (rd) begin
            bus.mem_read_idx = (state == S_LOAD_SCR) ? fb_idx : spr_idx;
        end
        unique case (1'b1)
            clr_wr: bus.mem_write_idx = FB_BASE + cnt;
            st_wr: begin
                bus.mem_write_idx  = fb_idx;
                bus.mem_write_byte = old_b ^ pk;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            cnt            <= '0;
            base           <= '0;
            xq             <= '0;
            row            <= '0;
            r              <= '0;
            rows           <= '0;
            wide_q         <= 1'b0;
            wrap_q         <= 1'b0;
            spr_hi         <= '0;
            spr_lo         <= '0;
            old_b          <= '0;
            pend           <= '0;
            row_flip       <= 1'b0;
            collision      <= 1'b0;
            collision_rows <= '0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (clear) begin
                        collision      <= 1'b0;
                        collision_rows <= '0;
                        cnt            <= '0;
                        state          <= S_CLEAR;
                    end else if (draw) begin
                        collision      <= 1'b0;
                        collision_rows <= '0;
                        base           <= addr;
                        xq             <= x_mod;
                        row            <= y_mod;
                        wide_q         <= wide;
                        wrap_q         <= wrap;
                        rows           <= rows_in;
                        r              <= '0;
                        row_flip       <= 1'b0;
                        if (rows_in == 5'd0) done  <= 1'b1;
                        else                 state <= S_LOAD_SPR_HI;
                    end
                end
                // one trailing cycle after the last byte before returning
                S_CLEAR: begin
                    if (cnt == 12'(NCLR)) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end
                S_LOAD_SPR_HI: begin
                    if (bus.mem_read_ack) begin
                        spr_hi <= bus.mem_read_byte;
                        spr_lo <= 8'h00;
                        if (wide_q) begin
                            state <= S_LOAD_SPR_LO;
                        end else begin
                            pend  <= vmask;
                            state <= S_LOAD_SCR;
                        end
                    end
                end
                S_LOAD_SPR_LO: begin
                    if (bus.mem_read_ack) begin
                        spr_lo <= bus.mem_read_byte;
                        pend   <= vmask;
                        state  <= S_LOAD_SCR;
                    end
                end
                S_LOAD_SCR: begin
                    if (bus.mem_read_ack) begin
                        old_b <= bus.mem_read_byte;
                        state <= S_STORE_SCR;
                    end
                end
                S_STORE_SCR: begin
                    collision <= collision | flip;
                    row_flip  <= row_flip | flip;
                    pend      <= pend_nx;
                    state     <= (pend_nx != 3'd0) ? S_LOAD_SCR : S_NEXT_ROW;
                end
                S_NEXT_ROW: begin
                    row_flip <= 1'b0;
                    if (row_flip) collision_rows <= collision_rows + 5'd1;
                    r <= r + 5'd1;
                    if (r + 5'd1 == rows) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end else if (row_nx >= 8'(SCREEN_H)) begin
                        if (wrap_q) begin
                            row   <= '0;
                            state <= S_LOAD_SPR_HI;
                        end else begin
                            state <= S_IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        row   <= row_nx[6:0];
                        state <= S_LOAD_SPR_HI;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized scoreboard bench for sprite_blitter.
// Memory model with random ack delay; pixel-level reference model.
module tb_sprite_blitter;
    localparam int          W  = 64;
    localparam int          H  = 32;
    localparam int          RB = W / 8;
    localparam logic [11:0] FB = 12'h100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw = 1'b0;
    logic        clear = 1'b0;
    logic        wide = 1'b0;
    logic        wrap = 1'b0;
    logic [11:0] addr = '0;
    logic [3:0]  lines = '0;
    logic [7:0]  x = '0;
    logic [7:0]  y = '0;
    logic        busy;
    logic        done;
    logic        collision;
    logic [4:0]  collision_rows;

    sprite_blitter_if bus ();

    sprite_blitter #(
        .SCREEN_W(W),
        .SCREEN_H(H),
        .FB_BASE (FB)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .draw          (draw),
        .clear         (clear),
        .wide          (wide),
        .wrap          (wrap),
        .addr          (addr),
        .lines         (lines),
        .x             (x),
        .y             (y),
        .busy          (busy),
        .done          (done),
        .collision     (collision),
        .collision_rows(collision_rows),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [4096];
    logic [7:0] ref_mem [4096];

    typedef struct packed {
        logic [11:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct packed {
        logic       c;
        logic [4:0] n;
    } dn_t;

    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int vectors = 0;
    int miscompares = 0;
    int nwr = 0;

    // memory responder: random 1..5 cycle ack latency
    initial begin
        bus.mem_read_ack  = 1'b0;
        bus.mem_read_byte = 8'h00;
        forever begin
            @(negedge clk);
            bus.mem_read_ack  = 1'b0;
            bus.mem_read_byte = 8'h00;
            if (bus.mem_read === 1'b1) begin
                repeat ($urandom_range(5, 1) - 1) @(negedge clk);
                bus.mem_read_byte = mem[bus.mem_read_idx];
                bus.mem_read_ack  = 1'b1;
            end
        end
    end

    // write monitor
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (bus.mem_write === 1'b1) begin
                nwr++;
                vectors++;
                if (exp_wr.size() == 0) begin
                    miscompares++;
                    $display("FAIL write_unexpected: got %h=%h, required no write",
                             bus.mem_write_idx, bus.mem_write_byte);
                end else begin
                    e = exp_wr.pop_front();
                    if (bus.mem_write_idx !== e.a || bus.mem_write_byte !== e.d) begin
                        miscompares++;
                        $display("FAIL write: got %h=%h, required %h=%h",
                                 bus.mem_write_idx, bus.mem_write_byte, e.a, e.d);
                    end
                end
                mem[bus.mem_write_idx] = bus.mem_write_byte;
            end
        end
    end

    // done monitor
    initial begin
        dn_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                vectors++;
                if (exp_dn.size() == 0) begin
                    miscompares++;
                    $display("FAIL done_unexpected: got done, required none");
                end else begin
                    e = exp_dn.pop_front();
                    if (collision !== e.c || collision_rows !== e.n) begin
                        miscompares++;
                        $display("FAIL status: got coll=%b rows=%0d, required coll=%b rows=%0d",
                                 collision, collision_rows, e.c, e.n);
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic set_byte(input logic [11:0] a, input logic [7:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic model_clear();
        wr_t t;
        dn_t s;
        for (int i = 0; i < RB * H; i++) begin
            t.a = FB + 12'(i);
            t.d = 8'h00;
            exp_wr.push_back(t);
            ref_mem[t.a] = 8'h00;
        end
        s.c = 1'b0;
        s.n = 5'd0;
        exp_dn.push_back(s);
    endtask

    // pixel-level model: each sprite pixel lands at screen column X+j
    task automatic model_draw(input bit w, input bit wr, input logic [11:0] a,
                              input logic [3:0] ln, input logic [7:0] xx,
                              input logic [7:0] yy);
        int X, Y, sh, c0, nb, width, nrows, R, C, col, crows;
        logic coll, rf;
        logic [15:0] spr;
        logic [7:0] pb, old;
        logic [11:0] ad;
        wr_t t;
        dn_t s;
        X = int'(xx) % W;
        Y = int'(yy) % H;
        sh = X % 8;
        c0 = X / 8;
        nb = w ? 3 : 2;
        width = w ? 16 : 8;
        nrows = (w && ln == 4'd0) ? 16 : int'(ln);
        crows = 0;
        coll = 1'b0;
        for (int r = 0; r < nrows; r++) begin
            R = Y + r;
            if (R >= H) begin
                if (wr) R -= H;
                else break;
            end
            if (w) spr = {ref_mem[a + 12'(2 * r)], ref_mem[a + 12'(2 * r + 1)]};
            else   spr = {8'h00, ref_mem[a + 12'(r)]};
            rf = 1'b0;
            for (int k = 0; k < nb; k++) begin
                if (sh == 0 && k == nb - 1) continue;
                C = c0 + k;
                if (C >= RB) begin
                    if (wr) C -= RB;
                    else continue;
                end
                pb = 8'h00;
                for (int b = 0; b < 8; b++) begin
                    col = 8 * k + b - sh;
                    if (col >= 0 && col < width) pb[7 - b] = spr[width - 1 - col];
                end
                ad = FB + 12'(R * RB + C);
                old = ref_mem[ad];
                if ((old & pb) != 8'h00) rf = 1'b1;
                ref_mem[ad] = old ^ pb;
                t.a = ad;
                t.d = old ^ pb;
                exp_wr.push_back(t);
            end
            if (rf) begin
                crows++;
                coll = 1'b1;
            end
        end
        s.c = coll;
        s.n = 5'(crows);
        exp_dn.push_back(s);
    endtask

    task automatic start_cmd(input bit is_clr, input bit both, input bit w,
                             input bit wr, input logic [11:0] a,
                             input logic [3:0] ln, input logic [7:0] xx,
                             input logic [7:0] yy);
        @(negedge clk);
        wide  = w;
        wrap  = wr;
        addr  = a;
        lines = ln;
        x     = xx;
        y     = yy;
        clear = is_clr;
        draw  = !is_clr || both;
        @(negedge clk);
        draw  = 1'b0;
        clear = 1'b0;
        wide  = 1'($urandom);
        wrap  = 1'($urandom);
        addr  = 12'($urandom);
        lines = 4'($urandom);
        x     = 8'($urandom);
        y     = 8'($urandom);
    endtask

    task automatic run(input bit is_clr, input bit both, input bit w, input bit wr,
                       input logic [11:0] a, input logic [3:0] ln,
                       input logic [7:0] xx, input logic [7:0] yy,
                       output int bc);
        int n;
        if (is_clr) model_clear();
        else        model_draw(w, wr, a, ln, xx, yy);
        start_cmd(is_clr, both, w, wr, a, ln, xx, yy);
        bc = 0;
        n = 0;
        while (done !== 1'b1 && n < 5000) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            n++;
        end
        chk("done_in_budget", 32'(n < 5000), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
        chk("status_drained", 32'(exp_dn.size()), 32'd0);
    endtask

    initial begin
        int bc, k0, n, errs;
        for (int i = 0; i < 4096; i++) set_byte(12'(i), 8'($urandom));

        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        chk("rst_rows", 32'(collision_rows), 32'd0);
        chk("rst_rd", {bus.mem_read, bus.mem_read_idx}, 32'd0);
        chk("rst_wr", {bus.mem_write, bus.mem_write_idx, bus.mem_write_byte}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // clear wins over a simultaneous draw
        run(1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 4'd1, 8'd3, 8'd0, bc);
        chk("clear_busy", 32'(bc), 32'd257);

        set_byte(12'h010, 8'hF0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 4'd1, 8'd3, 8'd0, bc);
        chk("d39_b0", 32'(mem[12'h100]), 32'h1E);
        chk("d39_b1", 32'(mem[12'h101]), 32'h00);
        chk("d39_coll", 32'(collision), 32'd0);
        run(1'b0, 1'b0, 1'b0, 1'b0, 12'h010, 4'd1, 8'd3, 8'd0, bc);
        repeat (3) @(negedge clk);
        chk("d39r_b0", 32'(mem[12'h100]), 32'h00);
        chk("d39r_coll", 32'(collision), 32'd1);
        chk("d39r_rows", 32'(collision_rows), 32'd1);

        set_byte(12'h020, 8'hFF);
        set_byte(12'h021, 8'hFF);
        run(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'd0, 8'd0, 8'd0, bc);
        run(1'b0, 1'b0, 1'b0, 1'b1, 12'h020, 4'd2, 8'd60, 8'd31, bc);
        chk("d40_1ff", 32'(mem[12'h1FF]), 32'h0F);
        chk("d40_1f8", 32'(mem[12'h1F8]), 32'hF0);
        chk("d40_107", 32'(mem[12'h107]), 32'h0F);
        chk("d40_100", 32'(mem[12'h100]), 32'hF0);

        run(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'd0, 8'd0, 8'd0, bc);
        k0 = nwr;
        run(1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 4'd2, 8'd60, 8'd31, bc);
        chk("d41_nwr", 32'(nwr - k0), 32'd1);
        chk("d41_1ff", 32'(mem[12'h1FF]), 32'h0F);
        chk("d41_1f8", 32'(mem[12'h1F8]), 32'h00);

        // empty narrow sprite: done with no memory traffic
        k0 = nwr;
        run(1'b0, 1'b0, 1'b0, 1'b0, 12'h020, 4'd0, 8'd5, 8'd5, bc);
        chk("empty_busy", 32'(bc), 32'd0);
        chk("empty_nwr", 32'(nwr - k0), 32'd0);

        for (int i = 0; i < 32; i++) set_byte(12'h040 + 12'(i), 8'hFF);
        run(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'd0, 8'd0, 8'd0, bc);
        k0 = nwr;
        run(1'b0, 1'b0, 1'b1, 1'b0, 12'h040, 4'd0, 8'd4, 8'd0, bc);
        chk("d42_nwr", 32'(nwr - k0), 32'd48);
        chk("d42_100", 32'(mem[12'h100]), 32'h0F);
        chk("d42_101", 32'(mem[12'h101]), 32'hFF);
        chk("d42_102", 32'(mem[12'h102]), 32'hF0);

        // redraw the same sprite and abort it during its third row
        model_draw(1'b1, 1'b0, 12'h040, 4'd0, 8'd4, 8'd0);
        k0 = nwr;
        start_cmd(1'b0, 1'b0, 1'b1, 1'b0, 12'h040, 4'd0, 8'd4, 8'd0);
        n = 0;
        while (nwr < k0 + 7 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_row2", 32'(nwr >= k0 + 7), 32'd1);
        chk("pre_abort_rows", 32'(collision_rows), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rows", 32'(collision_rows), 32'd0);
        chk("abort_coll", 32'(collision), 32'd0);
        chk("abort_wr", 32'(bus.mem_write), 32'd0);
        chk("abort_rd", 32'(bus.mem_read), 32'd0);
        exp_wr.delete();
        exp_dn.delete();
        k0 = nwr;
        repeat (8) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("abort_no_writes", 32'(nwr - k0), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);

        run(1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 4'd0, 8'd0, 8'd0, bc);
        for (int i = 0; i < 30; i++) begin
            run(1'b0, 1'b0, 1'($urandom), 1'($urandom),
                12'($urandom_range(8'hC0, 0)), 4'($urandom),
                8'($urandom), 8'($urandom), bc);
        end

        errs = 0;
        for (int i = 0; i < RB * H; i++) begin
            if (mem[FB + 12'(i)] !== ref_mem[FB + 12'(i)]) errs++;
        end
        chk("fb_final_diff_bytes", 32'(errs), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 SCREEN_W, 64, screen width in pixels; multiple of 8, 64 or 128.
REQ-002 SCREEN_H, 32, screen height in rows; 32 or 64.
REQ-003 FB_BASE, 12'h100, byte address of framebuffer row 0, byte 0; row-major, MSB = leftmost pixel.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous and active-low.
REQ-006 draw  in  1  start sprite draw; sampled only in IDLE.
REQ-007 clear  in  1  start framebuffer clear; sampled only in IDLE; wins over draw if both high.
REQ-008 wide  in  1  1 = 16x16 sprite (2 bytes/row), 0 = 8xN sprite (1 byte/row).
REQ-009 wrap  in  1  1 = pixels past right/bottom edge wrap, 0 = clipped.
REQ-010 addr  in  12  sprite base address.
REQ-011 lines  in  4  sprite rows; wide=1 and lines=0 means 16.
REQ-012 x, y  in  8 each  start coordinate.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse on return to IDLE.
REQ-015 collision  out  1  sticky OR of all pixel 1->0 flips in last draw.
REQ-016 collision_rows  out  5  count of sprite rows with at least one flip (0..16).
REQ-017 mem_read / mem_read_idx[11:0] / mem_read_byte[7:0] in / mem_read_ack in  read port.
REQ-018 mem_write / mem_write_idx[11:0] / mem_write_byte[7:0]  write port.

Function
REQ-019 RB = SCREEN_W/8 bytes per row; X = x mod SCREEN_W, Y = y mod SCREEN_H latched on start (start point always wraps).
REQ-020 States: IDLE, CLEAR, LOAD_SPR_HI, LOAD_SPR_LO, LOAD_SCR, STORE_SCR, NEXT_ROW.
REQ-021 Read handshake: mem_read and index held combinationally while in a LOAD_* state and mem_read_ack low; mem_read low in the ack cycle; data captured in the ack cycle; ack latency unbounded (>=1 cycle).
REQ-022 Writes: mem_write high exactly one cycle per byte, no ack; all mem_* outputs 0 when not reading/writing.
REQ-023 clear in IDLE: CLEAR writes 8'h00 to FB_BASE..FB_BASE+RB*SCREEN_H-1, one byte per cycle, ascending; then done; collision and collision_rows cleared at start.
REQ-024 draw in IDLE: collision<=0, collision_rows<=0; rows = wide&&lines==0 ? 16 : lines; rows==0 -> IDLE next cycle with done, no memory access.
REQ-025 Per row r: LOAD_SPR_HI reads addr+r (wide=0) or addr+2r (wide=1); LOAD_SPR_LO (wide=1 only) reads addr+2r+1.
REQ-026 Row pattern P = {sprite bytes, 8'h00} >> (X mod 8): 16 bits (wide=0) or 24 bits (wide=1); byte k of P (k=0 leftmost) targets column C = X/8 + k.
REQ-027 Byte count per row: 2 (wide=0) or 3 (wide=1); k with zero shift and P byte all-zero beyond sprite width skipped (no read/write).
REQ-028 Column C >= RB: wrap=1 -> C-RB; wrap=0 -> byte skipped.
REQ-029 Row R = Y + r: R >= SCREEN_H -> wrap=1 uses R-SCREEN_H, wrap=0 terminates draw (done) before that row.
REQ-030 Each byte: LOAD_SCR reads FB_BASE+R*RB+C; STORE_SCR writes old ^ P_k next cycle; flip = |(old & P_k).
REQ-031 collision |= flip every byte; collision_rows increments once per row in NEXT_ROW if any byte of the row flipped.
REQ-032 Address arithmetic in 12 bits; parameters guarantee FB_BASE+RB*SCREEN_H <= 4096.
REQ-033 draw/clear while busy ignored; inputs other than draw/clear sampled only at start.
REQ-034 collision and collision_rows hold their value in IDLE until next start.

Reset
REQ-035 rst_n low: state IDLE, busy=0, done=0, collision=0, collision_rows=0, all mem_* outputs 0, within same cycle (async).
REQ-036 Reset mid-draw or mid-clear aborts; no further writes; a partly drawn row stays partly drawn.
REQ-037 First draw/clear accepted on first rising edge with rst_n high.

Verification
REQ-038 Clear, SCREEN_W=64,H=32 -> 256 writes of 00 to 0x100..0x1FF, busy 257 cycles incl. start, done once.
REQ-039 draw x=3,y=0,lines=1,wide=0,sprite F0, screen 0 -> writes 0x100=1E, 0x101=00, collision=0; redraw -> 0x100=00, collision=1, collision_rows=1.
REQ-040 wrap=1, x=60,y=31,lines=2,sprite FF,FF -> row 31 bytes 0x1FF=0F, 0x1F8=F0; row 0 bytes 0x107=0F, 0x100=F0.
REQ-041 wrap=0, same stimulus -> only 0x1FF=0F written; draw ends after row 31, done pulses.
REQ-042 SCREEN_W=128,H=64, wide=1,lines=0,x=4,y=0, 16 rows of FFFF -> 48 writes, row0 0x100=0F,0x101=FF,0x102=F0; random ack delay 1-5 cycles gives identical memory.
REQ-043 rst_n low during third row of REQ-042 -> busy=0 immediately, no writes after, collision_rows=0.
